// File: rtl/donkey_pkg.sv
// Shared barrel types, direction encoding, default playfield geometry and the
// spawn LFSR step function used by barrel_ctl when BARREL_LFSR_SPAWN_EN is defined.
package donkey_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        FALL = 2'd2
    } barrel_state_t;

    localparam logic BARREL_DIR_R = 1'b0;
    localparam logic BARREL_DIR_L = 1'b1;

    localparam coord_t DEF_SPAWN_X        = 11'd200;
    localparam coord_t DEF_SPAWN_Y        = 11'd150;
    localparam coord_t DEF_X_MIN          = 11'd100;
    localparam coord_t DEF_X_MAX          = 11'd900;
    localparam coord_t DEF_PLATFORM_PITCH = 11'd100;
    localparam coord_t DEF_FLOOR_Y        = 11'd650;
    localparam coord_t DEF_ROLL_STEP      = 11'd2;
    localparam coord_t DEF_FALL_STEP      = 11'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/barrel_unit.sv
// One barrel slot: IDLE/ROLL/FALL state machine with its x, y, direction and
// fall-target registers; all outputs are flops updated only on run ticks.
module barrel_unit
    import donkey_pkg::*;
#(
    parameter coord_t SPAWN_X        = DEF_SPAWN_X,
    parameter coord_t SPAWN_Y        = DEF_SPAWN_Y,
    parameter coord_t X_MIN          = DEF_X_MIN,
    parameter coord_t X_MAX          = DEF_X_MAX,
    parameter coord_t PLATFORM_PITCH = DEF_PLATFORM_PITCH,
    parameter coord_t FLOOR_Y        = DEF_FLOOR_Y,
    parameter coord_t ROLL_STEP      = DEF_ROLL_STEP,
    parameter coord_t FALL_STEP      = DEF_FALL_STEP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   run,
    input  logic   tick,
    input  logic   spawn,
    output logic   active,
    output coord_t xpos,
    output coord_t ypos
);

    barrel_state_t state;
    logic          dir;
    coord_t        y_target;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active   <= 1'b0;
            dir      <= BARREL_DIR_R;
            xpos     <= '0;
            ypos     <= '0;
            y_target <= '0;
        end else if (clear) begin
            state    <= IDLE;
            active   <= 1'b0;
            dir      <= BARREL_DIR_R;
            xpos     <= '0;
            ypos     <= '0;
            y_target <= '0;
        end else if (run && tick) begin
            case (state)
                IDLE: begin
                    if (spawn) begin
                        state  <= ROLL;
                        active <= 1'b1;
                        dir    <= BARREL_DIR_R;
                        xpos   <= SPAWN_X;
                        ypos   <= SPAWN_Y;
                    end
                end
                ROLL: begin
                    // Edge test before the add/subtract so the coordinate never wraps.
                    if (dir == BARREL_DIR_R && xpos + ROLL_STEP < X_MAX) begin
                        xpos <= xpos + ROLL_STEP;
                    end else if (dir == BARREL_DIR_L && xpos > X_MIN + ROLL_STEP) begin
                        xpos <= xpos - ROLL_STEP;
                    end else begin
                        xpos <= (dir == BARREL_DIR_R) ? X_MAX : X_MIN;
                        if (ypos == FLOOR_Y) begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end else begin
                            state    <= FALL;
                            y_target <= ypos + PLATFORM_PITCH;
                        end
                    end
                end
                FALL: begin
                    if (ypos + FALL_STEP >= y_target) begin
                        ypos  <= y_target;
                        state <= ROLL;
                        dir   <= ~dir;
                    end else begin
                        ypos <= ypos + FALL_STEP;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_ctl.sv
// Barrel feeder: frame tick, spawn timer/arbiter and BARRELS slot instances.
// Define BARREL_LFSR_SPAWN_EN to jitter the spawn period with a 16-bit LFSR.
module barrel_ctl
    import donkey_pkg::*;
#(
    parameter int     BARRELS        = 5,
    parameter int     SPAWN_PERIOD   = 120,
    parameter coord_t SPAWN_X        = DEF_SPAWN_X,
    parameter coord_t SPAWN_Y        = DEF_SPAWN_Y,
    parameter coord_t X_MIN          = DEF_X_MIN,
    parameter coord_t X_MAX          = DEF_X_MAX,
    parameter coord_t PLATFORM_PITCH = DEF_PLATFORM_PITCH,
    parameter coord_t FLOOR_Y        = DEF_FLOOR_Y,
    parameter coord_t ROLL_STEP      = DEF_ROLL_STEP,
    parameter coord_t FALL_STEP      = DEF_FALL_STEP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_game,
    input  logic                       animation,
    input  logic                       vblnk,
    output logic [BARRELS-1:0]         barrel,
    output logic [BARRELS-1:0][10:0]   xpos,
    output logic [BARRELS-1:0][10:0]   ypos,
    output logic [7:0]                 spawn_cnt
);

    localparam logic [15:0] PERIOD_BASE = 16'(SPAWN_PERIOD);

    logic               vblnk_d;
    logic               tick;
    logic               run;
    logic               clear;
    logic [15:0]        frame_cnt;
    logic [15:0]        period;
    logic [BARRELS-1:0] spawn_sel;
    logic               slot_free;
    logic               spawn_due;

    assign run       = start_game && !animation;
    assign clear     = !start_game;
    assign spawn_due = tick && run && (frame_cnt + 16'd1 == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            tick    <= vblnk && !vblnk_d;
        end
    end

    // NOTE: defaults first so no path through the loop leaves a latch.
    always_comb begin
        spawn_sel = '0;
        slot_free = 1'b0;
        for (int i = 0; i < BARRELS; i++) begin
            if (!slot_free && !barrel[i]) begin
                spawn_sel[i] = 1'b1;
                slot_free    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            spawn_cnt <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            spawn_cnt <= '0;
        end else if (run && tick) begin
            if (spawn_due) begin
                frame_cnt <= '0;
                if (slot_free && spawn_cnt != 8'hFF) begin
                    spawn_cnt <= spawn_cnt + 8'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef BARREL_LFSR_SPAWN_EN
    logic [15:0] lfsr;

    // The effective period is latched from the LFSR at every reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= LFSR_SEED;
            period <= PERIOD_BASE + {11'd0, LFSR_SEED[4:0]};
        end else if (clear) begin
            period <= PERIOD_BASE + {11'd0, lfsr[4:0]};
        end else if (run && tick) begin
            lfsr <= lfsr_next(lfsr);
            if (spawn_due) begin
                period <= PERIOD_BASE + {11'd0, lfsr[4:0]};
            end
        end
    end
`else
    assign period = PERIOD_BASE;
`endif

    for (genvar i = 0; i < BARRELS; i++) begin : g_slot
        barrel_unit #(
            .SPAWN_X        (SPAWN_X),
            .SPAWN_Y        (SPAWN_Y),
            .X_MIN          (X_MIN),
            .X_MAX          (X_MAX),
            .PLATFORM_PITCH (PLATFORM_PITCH),
            .FLOOR_Y        (FLOOR_Y),
            .ROLL_STEP      (ROLL_STEP),
            .FALL_STEP      (FALL_STEP)
        ) u_unit (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .run    (run),
            .tick   (tick),
            .spawn  (spawn_due && spawn_sel[i]),
            .active (barrel[i]),
            .xpos   (xpos[i]),
            .ypos   (ypos[i])
        );
    end

endmodule
